// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings the system PLL out of reset, waits (with timeout) for a lock that
// stays stable for a full window, then releases the downstream domain resets
// one at a time, domain 0 first, and finally raises ready. Any lock loss once
// releases have begun drops every domain back into reset and restarts the
// whole sequence.
// Optional feature macro: PLLSEQ_STATS_EN adds saturating lock-loss and
// lock-timeout counters plus their output ports.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int STABLE_CYCLES  = 1024,
   parameter int NUM_DOMAINS    = 2,
   parameter int STAGE_CYCLES   = 64,
   parameter int CNT_W          = 8
) (
   input  logic                   refclk,
   input  logic                   rst_n,
   input  logic                   pll_locked,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst_n,
   output logic                   ready,
   output logic [2:0]             state_o
`ifdef PLLSEQ_STATS_EN
   ,
   output logic [CNT_W-1:0]       lock_loss_cnt,
   output logic [CNT_W-1:0]       timeout_cnt
`endif
);

   localparam logic [2:0] PLL_RESET = 3'd0;
   localparam logic [2:0] WAIT_LOCK = 3'd1;
   localparam logic [2:0] STABLE    = 3'd2;
   localparam logic [2:0] RELEASE   = 3'd3;
   localparam logic [2:0] RUN       = 3'd4;

   // The shared cycle counter must be able to hold the longest phase length.
   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B   = (STABLE_CYCLES > STAGE_CYCLES) ? STABLE_CYCLES : STAGE_CYCLES;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] STAGE_LAST   = CW'(STAGE_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOMAINS - 1);

   // Reject degenerate configurations at elaboration time.
   if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
       NUM_DOMAINS < 1 || STAGE_CYCLES < 1 || CNT_W < 1) begin : g_param_check
      $error("pll_reset_sequencer: all parameters must be >= 1");
   end

   logic          locked_m;
   logic          locked_s;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          loss_ev;
   logic          timeout_ev;

   // Lock loss only counts once domain releases have started; a drop during
   // STABLE is treated as a glitch and just restarts the lock wait.
   assign loss_ev    = ((state == RELEASE) || (state == RUN)) && !locked_s;
   assign timeout_ev = (state == WAIT_LOCK) && !locked_s && (cnt == TIMEOUT_LAST);
   assign state_o    = state;

   // Two-flop synchroniser for the asynchronous PLL lock indication.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         locked_m <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         // NOTE: non-blocking so locked_s takes last cycle's locked_m; blocking
         // here would collapse the two stages into one flop.
         locked_m <= pll_locked;
         locked_s <= locked_m;
      end
   end

   // Sequencing FSM; lock loss is checked first so it beats a completing stage.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state        <= PLL_RESET;
         cnt          <= '0;
         idx          <= '0;
         pll_rst      <= 1'b1;
         domain_rst_n <= '0;
         ready        <= 1'b0;
      end else if (loss_ev) begin
         state        <= PLL_RESET;
         cnt          <= '0;
         pll_rst      <= 1'b1;
         domain_rst_n <= '0;
         ready        <= 1'b0;
      end else begin
         case (state)
            PLL_RESET: begin
               if (cnt == PLL_RST_LAST) begin
                  state   <= WAIT_LOCK;
                  cnt     <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (timeout_ev) begin
                  state   <= PLL_RESET;
                  cnt     <= '0;
                  pll_rst <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE: begin
               if (!locked_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state <= RELEASE;
                  cnt   <= '0;
                  idx   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (cnt == STAGE_LAST) begin
                  domain_rst_n[idx] <= 1'b1;
                  cnt               <= '0;
                  if (idx == IDX_LAST) begin
                     state <= RUN;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               ready <= 1'b1;
            end
            default: begin
               state   <= PLL_RESET;
               cnt     <= '0;
               pll_rst <= 1'b1;
            end
         endcase
      end
   end

`ifdef PLLSEQ_STATS_EN
   // Saturating event counters; cleared only by rst_n, never by lock loss.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         lock_loss_cnt <= '0;
         timeout_cnt   <= '0;
      end else begin
         if (loss_ev && (lock_loss_cnt != '1)) begin
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
         end
         if (timeout_ev && (timeout_cnt != '1)) begin
            timeout_cnt <= timeout_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Drives directed and randomised pll_locked / rst_n sequences. A phase/age
// reference model predicts every output after each edge and queues it; a
// monitor on the falling edge pops and compares against the DUT.
// Define PLLSEQ_STATS_EN to also check the statistics counters.
module tb_pll_reset_sequencer;

   localparam int PRC = 4;
   localparam int LTO = 20;
   localparam int STC = 8;
   localparam int STG = 3;
   localparam int ND  = 2;
   localparam int CW  = 8;
   localparam int SAT = (1 << CW) - 1;

   logic          refclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pll_locked = 1'b0;
   logic          pll_rst;
   logic [ND-1:0] domain_rst_n;
   logic          ready;
   logic [2:0]    state_o;
`ifdef PLLSEQ_STATS_EN
   logic [CW-1:0] lock_loss_cnt;
   logic [CW-1:0] timeout_cnt;
`endif

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .STABLE_CYCLES(STC),
      .NUM_DOMAINS(ND), .STAGE_CYCLES(STG), .CNT_W(CW)
   ) dut (
      .refclk       (refclk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .pll_rst      (pll_rst),
      .domain_rst_n (domain_rst_n),
      .ready        (ready),
      .state_o      (state_o)
`ifdef PLLSEQ_STATS_EN
      ,
      .lock_loss_cnt(lock_loss_cnt),
      .timeout_cnt  (timeout_cnt)
`endif
   );

   always #5 refclk = ~refclk;

   typedef enum int {P_PR = 0, P_WL = 1, P_ST = 2, P_REL = 3, P_RUN = 4} phase_t;

   typedef struct {
      logic          pll_rst;
      logic [ND-1:0] dom;
      logic          ready;
      logic [2:0]    state;
      int            llc;
      int            toc;
   } exp_t;

   exp_t   exp_q[$];
   int     checks = 0;
   int     failures = 0;
   int     pushed = 0;
   int     popped = 0;
   int     cycle = 0;

   // Reference model: current phase and number of edges spent in it.
   phase_t ph = P_PR;
   int     age = 0;
   logic   h0 = 1'b0;
   logic   h1 = 1'b0;
   int     llc_m = 0;
   int     toc_m = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cycle, act, expv);
      end
   endtask

   // Advance the model by one rising edge and queue the outputs it predicts.
   task automatic step_model(input logic r, input logic lk);
      logic use_lk;
      int   k;
      exp_t e;
      if (!r) begin
         ph = P_PR; age = 0; h0 = 1'b0; h1 = 1'b0; llc_m = 0; toc_m = 0;
      end else begin
         use_lk = h1;     // lock as seen two edges after it was sampled
         h1 = h0;
         h0 = lk;
         if ((ph == P_REL || ph == P_RUN) && !use_lk) begin
            ph = P_PR; age = 0;
            llc_m = (llc_m < SAT) ? llc_m + 1 : SAT;
         end else begin
            case (ph)
               P_PR: begin
                  age++;
                  if (age == PRC) begin ph = P_WL; age = 0; end
               end
               P_WL: begin
                  if (use_lk) begin
                     ph = P_ST; age = 0;
                  end else begin
                     age++;
                     if (age == LTO) begin
                        ph = P_PR; age = 0;
                        toc_m = (toc_m < SAT) ? toc_m + 1 : SAT;
                     end
                  end
               end
               P_ST: begin
                  if (!use_lk) begin
                     ph = P_WL; age = 0;
                  end else begin
                     age++;
                     if (age == STC) begin ph = P_REL; age = 0; end
                  end
               end
               P_REL: begin
                  age++;
                  if (age == ND * STG) begin ph = P_RUN; age = 0; end
               end
               default: begin
                  if (age < 1000) age++;
               end
            endcase
         end
      end
      // Domains released so far follow from elapsed release time.
      if (ph == P_REL)      k = age / STG;
      else if (ph == P_RUN) k = ND;
      else                  k = 0;
      e.pll_rst = (ph == P_PR);
      e.dom     = ND'((1 << k) - 1);
      e.ready   = (ph == P_RUN) && (age >= 1);
      e.state   = 3'(int'(ph));
      e.llc     = llc_m;
      e.toc     = toc_m;
      exp_q.push_back(e);
      pushed++;
   endtask

   task automatic drive(input logic r, input logic lk, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge refclk);
         rst_n      = r;
         pll_locked = lk;
         @(posedge refclk);
         step_model(r, lk);
         cycle++;
      end
   endtask

   // Monitor: compare DUT outputs against the oldest prediction.
   exp_t mon_e;
   always @(negedge refclk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         popped++;
         check("pll_rst", 32'(pll_rst), 32'(mon_e.pll_rst));
         check("domain_rst_n", 32'(domain_rst_n), 32'(mon_e.dom));
         check("ready", 32'(ready), 32'(mon_e.ready));
         check("state_o", 32'(state_o), 32'(mon_e.state));
`ifdef PLLSEQ_STATS_EN
         check("lock_loss_cnt", 32'(lock_loss_cnt), mon_e.llc);
         check("timeout_cnt", 32'(timeout_cnt), mon_e.toc);
`endif
      end
   end

   initial begin
      int r;
      // Nominal bring-up: lock 10 cycles after pll_rst falls, run to ready.
      drive(1'b0, 1'b0, 2);
      drive(1'b1, 1'b0, PRC + 10);
      drive(1'b1, 1'b1, 30);
      // Loss in RUN, then full rerun.
      drive(1'b1, 1'b0, 1);
      drive(1'b1, 1'b1, 40);
      // Glitch during STABLE.
      drive(1'b0, 1'b0, 1);
      drive(1'b1, 1'b0, PRC + 2);
      drive(1'b1, 1'b1, 7);
      drive(1'b1, 1'b0, 1);
      drive(1'b1, 1'b1, 30);
      // Repeated timeouts.
      drive(1'b1, 1'b0, 3 * (PRC + LTO) + 5);
      // rst_n pulse after domain 0 released.
      drive(1'b0, 1'b0, 1);
      drive(1'b1, 1'b1, 20);
      drive(1'b0, 1'b1, 1);
      drive(1'b1, 1'b1, 30);
      // Randomised segments.
      for (int s = 0; s < 150; s++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4)      drive(1'b1, 1'b1, int'($urandom_range(15, 80)));
         else if (r < 6) drive(1'b1, 1'b0, int'($urandom_range(1, 3)));
         else if (r < 8) drive(1'b1, 1'b0, int'($urandom_range(10, 50)));
         else if (r < 9) drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
         else begin
            for (int j = 0; j < 10; j++) drive(1'b1, 1'($urandom_range(0, 1)), 1);
         end
      end
      // Timeout counter saturation (> 2^CNT_W timeouts).
      drive(1'b0, 1'b0, 1);
      drive(1'b1, 1'b0, 300 * (PRC + LTO) + 10);
      drive(1'b1, 1'b1, 30);
      // Let the monitor consume the final prediction.
      @(negedge refclk);
      @(negedge refclk);
      check("drain", 32'(popped), 32'(pushed));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
